// File: rtl/logic_ops_pkg.sv
// Shared opcode and FSM encodings for the bit-serial reduction controller,
// plus the helpers that define accumulator seeding and final result shaping.
package logic_ops_pkg;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // AND reduces from an all-ones identity, every other opcode from zero.
    function automatic logic acc_init(input logic [1:0] op);
        logic v;
        if (op == OP_AND) begin
            v = 1'b1;
        end else begin
            v = 1'b0;
        end
        return v;
    endfunction

    // NOR runs as OR through the gate; the inversion is applied only here.
    function automatic logic finalize(input logic [1:0] op, input logic acc);
        logic v;
        if (op == OP_NOR) begin
            v = ~acc;
        end else begin
            v = acc;
        end
        return v;
    endfunction

endpackage

// File: rtl/logic_unit.sv
// Single shared 1-bit gate. NOR is evaluated as OR; the caller inverts the
// final accumulated value.
module logic_unit
    import logic_ops_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);

    // Opcode-selected two-input gate.
    always_comb begin
        y = 1'b0;
        case (op)
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = a | b;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_logic_ctrl.sv
// Round-robin arbitrated, bit-serial OR/AND/XOR/NOR reduction over a single
// shared 1-bit gate, with registered grant/done/result outputs.
module serial_logic_ctrl
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             owner
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic             ptr_r;
    logic [WIDTH-1:0] shreg_r;
    logic [1:0]       op_r;
    logic             idx_r;
    logic             acc_r;
    logic [CW-1:0]    cnt_r;

    logic             gnt0_r;
    logic             gnt1_r;
    logic             busy_r;
    logic             done_r;
    logic             result_r;
    logic             owner_r;

    logic             accept_s;
    logic             win_s;
    logic             both_s;
    logic             last_bit_s;
    logic             gate_y_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [1:0]       sel_op_s;

    logic_unit u_gate (
        .a  (acc_r),
        .b  (shreg_r[0]),
        .op (op_r),
        .y  (gate_y_s)
    );

    // Next-state logic, arbitration and last-bit detection.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        win_s        = 1'b0;
        last_bit_s   = 1'b0;
        both_s       = req0 & req1;
        case (state_r)
            S_IDLE: begin
                if (req0 || req1) begin
                    accept_s     = 1'b1;
                    state_next_s = S_RUN;
                    if (both_s) begin
                        win_s = ptr_r;
                    end else if (req1) begin
                        win_s = 1'b1;
                    end else begin
                        win_s = 1'b0;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_r == LAST_BIT) begin
                    last_bit_s   = 1'b1;
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Winner operand/opcode selection for the accept edge.
    always_comb begin
        sel_data_s = data0;
        sel_op_s   = op0;
        if (win_s) begin
            sel_data_s = data1;
            sel_op_s   = op1;
        end else begin
            sel_data_s = data0;
            sel_op_s   = op0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Priority pointer: moves to the loser only when both requesters collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (accept_s && both_s) begin
            ptr_r <= ~win_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Operand latch on accept, then one shift/accumulate step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= '0;
            op_r    <= 2'b00;
            idx_r   <= 1'b0;
            acc_r   <= 1'b0;
            cnt_r   <= '0;
        end else if (accept_s) begin
            shreg_r <= sel_data_s;
            op_r    <= sel_op_s;
            idx_r   <= win_s;
            acc_r   <= acc_init(sel_op_s);
            cnt_r   <= '0;
        end else if (state_r == S_RUN) begin
            shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            acc_r   <= gate_y_s;
            cnt_r   <= cnt_r + CW'(1);
        end else begin
            shreg_r <= shreg_r;
            acc_r   <= acc_r;
            cnt_r   <= cnt_r;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            gnt0_r <= accept_s & ~win_s;
            gnt1_r <= accept_s & win_s;
            busy_r <= (state_next_s != S_IDLE);
            done_r <= last_bit_s;
        end
    end

    // Result/owner load on the final bit; held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= 1'b0;
            owner_r  <= 1'b0;
        end else if (last_bit_s) begin
            result_r <= finalize(op_r, gate_y_s);
            owner_r  <= idx_r;
        end else begin
            result_r <= result_r;
            owner_r  <= owner_r;
        end
    end

    assign gnt0   = gnt0_r;
    assign gnt1   = gnt1_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign owner  = owner_r;

endmodule

// File: tb/tb_serial_logic_ctrl.sv
// Directed, scoreboard-based bench for serial_logic_ctrl (WIDTH=8).
module tb_serial_logic_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic owner;
        logic result;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1;
    logic [1:0]       op0, op1;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1, busy, done, result, owner;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   gnt_cnt = 0;
    int   done_cnt = 0;
    int   gnt_hist[$];
    int   done_hist[$];
    logic exp_gnt_q[$];
    res_t exp_res_q[$];
    logic mon_e;
    res_t mon_r;

    serial_logic_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .op0    (op0),
        .op1    (op1),
        .data0  (data0),
        .data1  (data1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .busy   (busy),
        .done   (done),
        .result (result),
        .owner  (owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic exp_reduce(input logic [1:0] op, input logic [WIDTH-1:0] d);
        case (op)
            2'b00:   return |d;
            2'b01:   return &d;
            2'b10:   return ^d;
            default: return ~(|d);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every grant and every done is matched against queued expectations.
    always @(negedge clk) begin
        if (gnt0 || gnt1) begin
            if (exp_gnt_q.size() == 0) begin
                chk("gnt_unexpected", {30'd0, gnt1, gnt0}, 32'd0);
            end else begin
                mon_e = exp_gnt_q.pop_front();
                chk("gnt_who", {30'd0, gnt1, gnt0}, mon_e ? 32'd2 : 32'd1);
            end
            gnt_hist.push_back(cyc);
            gnt_cnt = gnt_cnt + 1;
        end
        if (done) begin
            if (exp_res_q.size() == 0) begin
                chk("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                mon_r = exp_res_q.pop_front();
                chk("result", {31'd0, result}, {31'd0, mon_r.result});
                chk("owner", {31'd0, owner}, {31'd0, mon_r.owner});
            end
            done_hist.push_back(cyc);
            done_cnt = done_cnt + 1;
        end
    end

    task automatic wait_gnt(input int n, input string tag);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (gnt_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input int n, input string tag);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic push_exp(input logic who, input logic [1:0] op, input logic [WIDTH-1:0] d);
        res_t r;
        r.owner  = who;
        r.result = exp_reduce(op, d);
        exp_gnt_q.push_back(who);
        exp_res_q.push_back(r);
    endtask

    task automatic single_op(input logic who, input logic [1:0] op, input logic [WIDTH-1:0] d);
        int rc, g0, d0;
        @(posedge clk); #1;
        if (who) begin
            req1 = 1'b1; op1 = op; data1 = d;
        end else begin
            req0 = 1'b1; op0 = op; data0 = d;
        end
        push_exp(who, op, d);
        rc = cyc; g0 = gnt_cnt; d0 = done_cnt;
        wait_gnt(g0 + 1, "gnt_wait");
        req0 = 1'b0; req1 = 1'b0;
        chk("gnt_latency", gnt_hist[$] - rc, 32'd1);
        chk("busy_run", {31'd0, busy}, 32'd1);
        wait_done(d0 + 1, "done_wait");
        chk("done_latency", done_hist[$] - gnt_hist[$], WIDTH);
        @(posedge clk); #1;
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
        chk({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_result"}, {31'd0, result}, 32'd0);
        chk({tag, "_owner"}, {31'd0, owner}, 32'd0);
    endtask

    initial begin
        int g0, d0, dsave, rc;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        data0 = 8'h00; data1 = 8'h00;
        #23;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("post_reset");

        // Single-requester reductions.
        single_op(1'b0, 2'b00, 8'h00);
        single_op(1'b0, 2'b00, 8'h10);
        single_op(1'b0, 2'b01, 8'hFF);
        single_op(1'b0, 2'b01, 8'hFE);
        single_op(1'b0, 2'b10, 8'hA5);
        single_op(1'b0, 2'b10, 8'h07);
        single_op(1'b0, 2'b11, 8'h00);
        single_op(1'b0, 2'b11, 8'h01);

        // Operand change during RUN must not affect the result.
        @(posedge clk); #1;
        req0 = 1'b1; op0 = 2'b00; data0 = 8'h00;
        push_exp(1'b0, 2'b00, 8'h00);
        g0 = gnt_cnt; d0 = done_cnt;
        wait_gnt(g0 + 1, "gnt_wait_chg");
        req0 = 1'b0; data0 = 8'hFF;
        wait_done(d0 + 1, "done_wait_chg");
        repeat (2) @(posedge clk);
        #1;

        // Both requesters held: alternating grants, 10 cycles apart.
        req0 = 1'b1; op0 = 2'b00; data0 = 8'h01;
        req1 = 1'b1; op1 = 2'b01; data1 = 8'h0F;
        push_exp(1'b0, 2'b00, 8'h01);
        push_exp(1'b1, 2'b01, 8'h0F);
        push_exp(1'b0, 2'b00, 8'h01);
        push_exp(1'b1, 2'b01, 8'h0F);
        g0 = gnt_cnt; d0 = done_cnt;
        for (int i = 1; i <= 4; i++) begin
            wait_gnt(g0 + i, "gnt_wait_rr");
            if (i > 1) begin
                chk("rr_spacing", gnt_hist[$] - gnt_hist[$-1], 32'd10);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_done(d0 + 4, "done_wait_rr");
        repeat (2) @(posedge clk);

        // Leave result=1/owner=1 so the async reset has something to clear.
        single_op(1'b1, 2'b10, 8'h07);

        // Collision (req0 wins, pointer moves to req1), then abort at E4.
        @(posedge clk); #1;
        req0 = 1'b1; op0 = 2'b01; data0 = 8'hFF;
        req1 = 1'b1; op1 = 2'b00; data1 = 8'hFF;
        exp_gnt_q.push_back(1'b0);
        g0 = gnt_cnt;
        wait_gnt(g0 + 1, "gnt_wait_abort");
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("abort");
        dsave = done_cnt;
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_cnt, dsave);

        // After reset the pointer favours req0; req1 stays high and wins next.
        req0 = 1'b1; op0 = 2'b00; data0 = 8'h10;
        req1 = 1'b1; op1 = 2'b11; data1 = 8'h00;
        push_exp(1'b0, 2'b00, 8'h10);
        push_exp(1'b1, 2'b11, 8'h00);
        g0 = gnt_cnt; d0 = done_cnt;
        wait_gnt(g0 + 1, "gnt_wait_prio");
        req0 = 1'b0;
        wait_gnt(g0 + 2, "gnt_wait_prio2");
        req1 = 1'b0;
        chk("prio_spacing", gnt_hist[$] - gnt_hist[$-1], 32'd10);
        wait_done(d0 + 2, "done_wait_prio");
        repeat (2) @(posedge clk);

        // req1 held through done: re-accepted at E10 with its new operand.
        #1;
        req1 = 1'b1; op1 = 2'b00; data1 = 8'h80;
        push_exp(1'b1, 2'b00, 8'h80);
        rc = cyc; g0 = gnt_cnt; d0 = done_cnt;
        wait_gnt(g0 + 1, "gnt_wait_hold");
        data1 = 8'h00;
        push_exp(1'b1, 2'b00, 8'h00);
        wait_gnt(g0 + 2, "gnt_wait_hold2");
        req1 = 1'b0;
        chk("hold_accept_edge", gnt_hist[$] - rc, 32'd11);
        wait_done(d0 + 2, "done_wait_hold");
        repeat (20) @(posedge clk);
        #1;
        chk("hold_no_extra_gnt", gnt_cnt, g0 + 2);

        chk("gnt_queue_empty", exp_gnt_q.size(), 32'd0);
        chk("res_queue_empty", exp_res_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
